turn_queue: RTL and testbench

//  Buffers player turn requests between keyboard_tracker (level outputs, hold mode) and control.

---
 rtl/snake_pkg.sv | 19 +
 rtl/key_edge_detect.sv | 48 ++++
 rtl/turn_queue.sv | 136 +++++++++++++
 tb/tb_turn_queue.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared heading encoding for the snake game: used by control, datapath and the turn queue.
// Pure declarations, no logic; opposite() flips the low bit to reverse a heading.
// No flow control.
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t LEFT  = 2'b00;
    localparam dir_t RIGHT = 2'b01;
    localparam dir_t UP    = 2'b10;
    localparam dir_t DOWN  = 2'b11;

    localparam int KEY_N = 4;

    function automatic dir_t opposite(input dir_t d);
        return d ^ 2'b01;
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Turns four held-key levels into a registered single press (priority down > up > right > left).
// Latency: 1 cycle from key rising to press_vld.
// No backpressure: a press is presented for one cycle and never held.
module key_edge_detect
    import snake_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       left,
    input  logic       right,
    input  logic       up,
    input  logic       down,
    output logic       press_vld,
    output logic [1:0] press_dat
);

    logic [KEY_N-1:0] key_lvl;
    logic [KEY_N-1:0] key_q;
    logic [KEY_N-1:0] key_rise;
    dir_t             sel;

    assign key_lvl  = {down, up, right, left};
    assign key_rise = key_lvl & ~key_q;

    always_comb begin
        sel = LEFT;
        if (key_rise[3])
            sel = DOWN;
        else if (key_rise[2])
            sel = UP;
        else if (key_rise[1])
            sel = RIGHT;
    end

    // History loads live levels in reset so a key held through reset is not a press.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            key_q     <= key_lvl;
            press_vld <= 1'b0;
            press_dat <= LEFT;
        end else begin
            key_q     <= key_lvl;
            press_vld <= |key_rise;
            press_dat <= sel;
        end
    end

endmodule

// File: rtl/turn_queue.sv
// Queues accepted turn presses and releases one per step; optional drop stats via TURN_QUEUE_STATS_EN.
// Latency: key edge -> count 2 cycles, step -> direction 1 cycle.
// Always ready; presses arriving while full (no step) are discarded and flagged on drop.
module turn_queue
    import snake_pkg::*;
#(
    parameter int         DEPTH    = 4,
    parameter logic [1:0] DIR_INIT = 2'b01
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     left,
    input  logic                     right,
    input  logic                     up,
    input  logic                     down,
    input  logic                     step,
    input  logic                     flush,
    output logic [1:0]               direction,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     drop,
    output logic [7:0]               drop_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic          press_vld;
    logic [1:0]    press_dat;

    dir_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_last;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;
    dir_t          dir_q;
    logic          drop_q;

    logic          empty;
    logic          is_full;
    dir_t          tail;
    logic          accept;
    logic          bypass;
    logic          do_push;
    logic          do_pop;
    logic          discard;

    key_edge_detect u_key_edge (
        .clk       (clk),
        .resetn    (resetn),
        .left      (left),
        .right     (right),
        .up        (up),
        .down      (down),
        .press_vld (press_vld),
        .press_dat (press_dat)
    );

    assign wr_last = wr_ptr - 1'b1;
    assign empty   = (cnt_q == '0);
    assign is_full = (cnt_q == CNT_MAX);

    always_comb begin
        tail    = empty ? dir_q : mem[wr_last];
        accept  = press_vld && (press_dat != tail) && (press_dat != opposite(tail));
        do_pop  = step && !empty;
        // An accepted press meeting a step on an empty queue goes straight to the heading.
        bypass  = accept && step && empty;
        do_push = accept && !bypass && (!is_full || step);
        discard = accept && is_full && !step;
    end

    always_comb begin
        cnt_nxt = cnt_q;
        if (do_push && !do_pop)
            cnt_nxt = cnt_q + 1'b1;
        else if (do_pop && !do_push)
            cnt_nxt = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            dir_q  <= DIR_INIT;
            cnt_q  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            drop_q <= 1'b0;
        end else if (flush) begin
            dir_q  <= DIR_INIT;
            cnt_q  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            drop_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_nxt;
            drop_q <= discard;
            if (do_pop) begin
                dir_q  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end else if (bypass) begin
                dir_q  <= press_dat;
            end
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
        end
    end

    // Storage needs no reset: an entry is only read once count covers it.
    always_ff @(posedge clk) begin
        if (resetn && !flush && do_push)
            mem[wr_ptr] <= press_dat;
    end

`ifdef TURN_QUEUE_STATS_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (!resetn)
            drop_cnt_q <= 8'h00;
        else if (!flush && discard && (drop_cnt_q != 8'hFF))
            drop_cnt_q <= drop_cnt_q + 8'd1;
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 8'h00;
`endif

    assign direction = dir_q;
    assign count     = cnt_q;
    assign full      = is_full;
    assign drop      = drop_q;

endmodule

// File: tb/tb_turn_queue.sv
// Cycle table bench for turn_queue: each row drives one cycle and states the outputs after that edge.
module tb_turn_queue;

    logic       clk = 1'b0;
    logic       resetn;
    logic       left, right, up, down;
    logic       step, flush;
    logic [1:0] direction;
    logic [2:0] count;
    logic       full;
    logic       drop;
    logic [7:0] drop_count;

    always #5 clk = ~clk;

    turn_queue #(.DEPTH(4), .DIR_INIT(2'b01)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .left       (left),
        .right      (right),
        .up         (up),
        .down       (down),
        .step       (step),
        .flush      (flush),
        .direction  (direction),
        .count      (count),
        .full       (full),
        .drop       (drop),
        .drop_count (drop_count)
    );

    typedef struct {
        logic [3:0] keys;
        logic       step;
        logic       flush;
        logic       rstn;
        logic [1:0] dir;
        logic [2:0] cnt;
        logic       drop;
    } vec_t;

    typedef struct {
        logic [1:0] dir;
        logic [2:0] cnt;
        logic       full;
        logic       drop;
        logic [7:0] dc;
    } exp_t;

    localparam logic [3:0] K0 = 4'b0000;
    localparam logic [3:0] KL = 4'b0001;
    localparam logic [3:0] KR = 4'b0010;
    localparam logic [3:0] KU = 4'b0100;
    localparam logic [3:0] KD = 4'b1000;

    vec_t       tbl[$];
    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         row    = 0;
    logic [7:0] exp_dc = 8'h00;

    function automatic vec_t mk(input logic [3:0] k, input logic s, input logic f, input logic r,
                                input logic [1:0] d, input logic [2:0] c, input logic dr);
        vec_t v;
        v.keys = k; v.step = s; v.flush = f; v.rstn = r;
        v.dir = d; v.cnt = c; v.drop = dr;
        return v;
    endfunction

    task automatic add(input logic [3:0] k, input logic s, input logic f,
                       input logic [1:0] d, input logic [2:0] c, input logic dr);
        tbl.push_back(mk(k, s, f, 1'b1, d, c, dr));
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL row %0d %s: got %0d expected %0d", row, name, act, req);
        end
    endtask

    task automatic run(input vec_t v);
        exp_t e;
        @(negedge clk);
        {down, up, right, left} = v.keys;
        step   = v.step;
        flush  = v.flush;
        resetn = v.rstn;
`ifdef TURN_QUEUE_STATS_EN
        if (!v.rstn)
            exp_dc = 8'h00;
        else if (v.drop && exp_dc != 8'hFF)
            exp_dc = exp_dc + 8'd1;
`endif
        e.dir  = v.dir;
        e.cnt  = v.cnt;
        e.full = (v.cnt == 3'd4);
        e.drop = v.drop;
        e.dc   = exp_dc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("direction", int'(direction), int'(e.dir));
            chk("count", int'(count), int'(e.cnt));
            chk("full", int'(full), int'(e.full));
            chk("drop", int'(drop), int'(e.drop));
            chk("drop_count", int'(drop_count), int'(e.dc));
        end
        row++;
    endtask

    initial begin
        resetn = 1'b0;
        {down, up, right, left} = KR;
        step  = 1'b0;
        flush = 1'b0;

        // Reset with RIGHT held: no press afterwards, heading stays RIGHT.
        run(mk(KR, 0, 0, 0, 2'b01, 3'd0, 0));
        run(mk(KR, 0, 0, 0, 2'b01, 3'd0, 0));
        for (int i = 0; i < 20; i++)
            run(mk(KR, 0, 0, 1, 2'b01, 3'd0, 0));
        run(mk(K0, 0, 0, 1, 2'b01, 3'd0, 0));

        // UP then LEFT ten cycles apart, then two steps.
        add(KU, 0, 0, 2'b01, 3'd0, 0);
        add(KU, 0, 0, 2'b01, 3'd1, 0);
        for (int i = 0; i < 8; i++)
            add(K0, 0, 0, 2'b01, 3'd1, 0);
        add(KL, 0, 0, 2'b01, 3'd1, 0);
        add(KL, 0, 0, 2'b01, 3'd2, 0);
        add(K0, 0, 0, 2'b01, 3'd2, 0);
        add(K0, 1, 0, 2'b10, 3'd1, 0);
        add(K0, 1, 0, 2'b00, 3'd0, 0);
        add(K0, 0, 1, 2'b01, 3'd0, 0);
        // Opposite and duplicate presses rejected.
        add(KL, 0, 0, 2'b01, 3'd0, 0);
        add(KL, 0, 0, 2'b01, 3'd0, 0);
        add(K0, 0, 0, 2'b01, 3'd0, 0);
        add(KR, 0, 0, 2'b01, 3'd0, 0);
        add(KR, 0, 0, 2'b01, 3'd0, 0);
        add(K0, 0, 0, 2'b01, 3'd0, 0);
        // Simultaneous rises: priority selection.
        add(KU | KL, 0, 0, 2'b01, 3'd0, 0);
        add(KU | KL, 0, 0, 2'b01, 3'd1, 0);
        add(K0, 0, 0, 2'b01, 3'd1, 0);
        add(K0, 1, 0, 2'b10, 3'd0, 0);
        add(K0, 0, 1, 2'b01, 3'd0, 0);
        add(KD | KU, 0, 0, 2'b01, 3'd0, 0);
        add(KD | KU, 0, 0, 2'b01, 3'd1, 0);
        add(K0, 1, 0, 2'b11, 3'd0, 0);
        add(K0, 0, 1, 2'b01, 3'd0, 0);
        // Fill to DEPTH, fifth press dropped.
        add(KU, 0, 0, 2'b01, 3'd0, 0);
        add(K0, 0, 0, 2'b01, 3'd1, 0);
        add(KL, 0, 0, 2'b01, 3'd1, 0);
        add(K0, 0, 0, 2'b01, 3'd2, 0);
        add(KD, 0, 0, 2'b01, 3'd2, 0);
        add(K0, 0, 0, 2'b01, 3'd3, 0);
        add(KR, 0, 0, 2'b01, 3'd3, 0);
        add(K0, 0, 0, 2'b01, 3'd4, 0);
        add(KU, 0, 0, 2'b01, 3'd4, 0);
        add(K0, 0, 0, 2'b01, 3'd4, 1);
        add(K0, 0, 0, 2'b01, 3'd4, 0);
        // Drain, including a step on an empty queue.
        add(K0, 1, 0, 2'b10, 3'd3, 0);
        add(K0, 1, 0, 2'b00, 3'd2, 0);
        add(K0, 1, 0, 2'b11, 3'd1, 0);
        add(K0, 1, 0, 2'b01, 3'd0, 0);
        add(K0, 1, 0, 2'b01, 3'd0, 0);
        // Refill, then press and step together while full.
        add(KU, 0, 0, 2'b01, 3'd0, 0);
        add(K0, 0, 0, 2'b01, 3'd1, 0);
        add(KL, 0, 0, 2'b01, 3'd1, 0);
        add(K0, 0, 0, 2'b01, 3'd2, 0);
        add(KD, 0, 0, 2'b01, 3'd2, 0);
        add(K0, 0, 0, 2'b01, 3'd3, 0);
        add(KR, 0, 0, 2'b01, 3'd3, 0);
        add(K0, 0, 0, 2'b01, 3'd4, 0);
        add(KU, 0, 0, 2'b01, 3'd4, 0);
        add(K0, 1, 0, 2'b10, 3'd4, 0);
        add(K0, 0, 0, 2'b10, 3'd4, 0);
        add(K0, 0, 1, 2'b01, 3'd0, 0);
        // Heading UP, LEFT press edge coincides with step: bypass.
        add(KU, 0, 0, 2'b01, 3'd0, 0);
        add(K0, 0, 0, 2'b01, 3'd1, 0);
        add(K0, 1, 0, 2'b10, 3'd0, 0);
        add(KL, 0, 0, 2'b10, 3'd0, 0);
        add(K0, 1, 0, 2'b00, 3'd0, 0);
        add(K0, 0, 0, 2'b00, 3'd0, 0);

        for (int i = 0; i < tbl.size(); i++)
            run(tbl[i]);

        // Three queued, then flush with step and an acceptable DOWN press in the same cycle.
        run(mk(KU, 0, 0, 1, 2'b00, 3'd0, 0));
        run(mk(K0, 0, 0, 1, 2'b00, 3'd1, 0));
        run(mk(K0, 1, 0, 1, 2'b10, 3'd0, 0));
        run(mk(KL, 0, 0, 1, 2'b10, 3'd0, 0));
        run(mk(K0, 0, 0, 1, 2'b10, 3'd1, 0));
        run(mk(KD, 0, 0, 1, 2'b10, 3'd1, 0));
        run(mk(K0, 0, 0, 1, 2'b10, 3'd2, 0));
        run(mk(KR, 0, 0, 1, 2'b10, 3'd2, 0));
        run(mk(K0, 0, 0, 1, 2'b10, 3'd3, 0));
        run(mk(KD, 0, 0, 1, 2'b10, 3'd3, 0));
        run(mk(KD, 1, 1, 1, 2'b01, 3'd0, 0));
        run(mk(K0, 0, 0, 1, 2'b01, 3'd0, 0));
        // Reset in the middle of a non-empty queue.
        run(mk(KU, 0, 0, 1, 2'b01, 3'd0, 0));
        run(mk(K0, 0, 0, 1, 2'b01, 3'd1, 0));
        run(mk(KL, 0, 0, 1, 2'b01, 3'd1, 0));
        run(mk(K0, 0, 0, 1, 2'b01, 3'd2, 0));
        run(mk(K0, 0, 0, 0, 2'b01, 3'd0, 0));
        run(mk(K0, 0, 0, 0, 2'b01, 3'd0, 0));
        run(mk(K0, 0, 0, 1, 2'b01, 3'd0, 0));
        run(mk(K0, 1, 0, 1, 2'b01, 3'd0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
